// File: rtl/lion_gate_pkg.sv
// ============================================================================
// Module : lion_gate_pkg
// Brief  : Shared state type and constants for the lion gate decoder.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lion_gate_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_E1     = 3'd1,
    S_E2     = 3'd2,
    S_E3     = 3'd3,
    S_X1     = 3'd4,
    S_X2     = 3'd5,
    S_X3     = 3'd6,
    S_RESYNC = 3'd7
  } state_t;

  localparam int ERR_CNT_W           = 4;
  localparam int SYNC_STAGES_DEFAULT = 2;

endpackage

`default_nettype wire

// File: rtl/lion_gate_decoder_debounce.sv
// ============================================================================
// Module : gate_debounce
// Brief  : Input synchronizer followed by a stable-count debouncer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gate_debounce
  import lion_gate_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_clean
);

  localparam logic [7:0] c_last = 8'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [7:0]             r_cnt;
  logic                   r_clean;
  logic                   w_sync;

  assign w_sync = r_sync[SYNC_STAGES-1];

  // The level flips on the edge where the counter would reach DEBOUNCE_CYCLES.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_clean <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
      if (w_sync == r_clean) begin
        r_cnt <= '0;
      end else if (r_cnt == c_last) begin
        r_clean <= ~r_clean;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  assign o_clean = r_clean;

endmodule

`default_nettype wire

// File: rtl/lion_gate_decoder.sv
// ============================================================================
// Module : lion_gate_decoder
// Brief  : Two-barrier direction decoder emitting entry/exit strobes.
//          Optional error counter enabled by LION_GATE_ERRCNT_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lion_gate_decoder
  import lion_gate_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 gate_a_raw,
  input  logic                 gate_b_raw,
  output logic                 enter_pulse,
  output logic                 exit_pulse,
  output logic                 gate_a,
  output logic                 gate_b,
  output logic                 busy,
  output logic [ERR_CNT_W-1:0] err_count
);

  state_t     r_state;
  state_t     w_state_nx;
  logic       r_enter;
  logic       r_exit;
  logic       w_enter_nx;
  logic       w_exit_nx;
  logic [1:0] w_code;

  gate_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_deb_a (
    .clk     (clk),
    .reset   (reset),
    .i_raw   (gate_a_raw),
    .o_clean (gate_a)
  );

  gate_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_deb_b (
    .clk     (clk),
    .reset   (reset),
    .i_raw   (gate_b_raw),
    .o_clean (gate_b)
  );

  assign w_code = {gate_a, gate_b};

  always_comb begin
    w_state_nx = r_state;
    w_enter_nx = 1'b0;
    w_exit_nx  = 1'b0;
    case (r_state)
      S_IDLE: case (w_code)
        2'b10:   w_state_nx = S_E1;
        2'b01:   w_state_nx = S_X1;
        2'b11:   w_state_nx = S_RESYNC;
        default: ;
      endcase
      S_E1: case (w_code)
        2'b00:   w_state_nx = S_IDLE;
        2'b11:   w_state_nx = S_E2;
        2'b01:   w_state_nx = S_RESYNC;
        default: ;
      endcase
      S_E2: case (w_code)
        2'b10:   w_state_nx = S_E1;
        2'b01:   w_state_nx = S_E3;
        2'b00:   w_state_nx = S_RESYNC;
        default: ;
      endcase
      S_E3: case (w_code)
        2'b00: begin
          w_state_nx = S_IDLE;
          w_enter_nx = 1'b1;
        end
        2'b11:   w_state_nx = S_E2;
        2'b10:   w_state_nx = S_RESYNC;
        default: ;
      endcase
      S_X1: case (w_code)
        2'b00:   w_state_nx = S_IDLE;
        2'b11:   w_state_nx = S_X2;
        2'b10:   w_state_nx = S_RESYNC;
        default: ;
      endcase
      S_X2: case (w_code)
        2'b01:   w_state_nx = S_X1;
        2'b10:   w_state_nx = S_X3;
        2'b00:   w_state_nx = S_RESYNC;
        default: ;
      endcase
      S_X3: case (w_code)
        2'b00: begin
          w_state_nx = S_IDLE;
          w_exit_nx  = 1'b1;
        end
        2'b11:   w_state_nx = S_X2;
        2'b01:   w_state_nx = S_RESYNC;
        default: ;
      endcase
      S_RESYNC: if (w_code == 2'b00) w_state_nx = S_IDLE;
      default:  w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_enter <= 1'b0;
      r_exit  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_enter <= w_enter_nx;
      r_exit  <= w_exit_nx;
    end
  end

  assign enter_pulse = r_enter;
  assign exit_pulse  = r_exit;
  assign busy        = (r_state != S_IDLE);

`ifdef LION_GATE_ERRCNT_EN
  logic                 w_err;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  assign w_err = (w_state_nx == S_RESYNC) && (r_state != S_RESYNC);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err_cnt <= '0;
    end else if (w_err && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
    end
  end

  assign err_count = r_err_cnt;
`else
  assign err_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lion_gate_decoder.sv
// ============================================================================
// Module : tb_lion_gate_decoder
// Brief  : Scoreboard bench with a table-driven reference model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_lion_gate_decoder;

  localparam int DEB  = 4;
  localparam int SYN  = 2;
  localparam int M_IDLE = 0;
  localparam int M_E3   = 3;
  localparam int M_X3   = 6;
  localparam int M_RS   = 7;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       gate_a_raw = 1'b0;
  logic       gate_b_raw = 1'b0;
  logic       enter_pulse, exit_pulse, gate_a, gate_b, busy;
  logic [3:0] err_count;

  lion_gate_decoder #(
    .DEBOUNCE_CYCLES (DEB),
    .SYNC_STAGES     (SYN)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .gate_a_raw  (gate_a_raw),
    .gate_b_raw  (gate_b_raw),
    .enter_pulse (enter_pulse),
    .exit_pulse  (exit_pulse),
    .gate_a      (gate_a),
    .gate_b      (gate_b),
    .busy        (busy),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ga;
    logic       gb;
    logic       busy;
    logic       en;
    logic       ex;
    logic [3:0] err;
  } stat_t;

  typedef struct {
    int kind;
    int cyc;
  } pulse_t;

  stat_t  sq[$];
  pulse_t pq[$];
  int     n_tests = 0;
  int     n_fail  = 0;

  // Rows: IDLE,E1,E2,E3,X1,X2,X3,RESYNC; columns: code 00,01,10,11 ({a,b}).
  int tbl [8][4] = '{
    '{0, 4, 1, 7},
    '{0, 7, 1, 2},
    '{7, 3, 1, 2},
    '{0, 3, 7, 2},
    '{0, 4, 7, 5},
    '{7, 4, 6, 5},
    '{0, 7, 6, 5},
    '{0, 7, 7, 7}
  };

  // Reference model: evaluated at each rising edge on the pre-edge view.
  initial begin
    logic [SYN-1:0] sy [2];
    logic           cl [2];
    int             cn [2];
    int             st, nst, code, err, ncyc;
    logic           en, ex, live, raw;
    stat_t          s;
    pulse_t         p;
    st = M_IDLE; err = 0; ncyc = 0; en = 1'b0; ex = 1'b0; live = 1'b0;
    for (int c = 0; c < 2; c++) begin
      sy[c] = '0; cl[c] = 1'b0; cn[c] = 0;
    end
    forever begin
      @(posedge clk);
      ncyc++;
      if (reset) begin
        for (int c = 0; c < 2; c++) begin
          sy[c] = '0; cl[c] = 1'b0; cn[c] = 0;
        end
        st = M_IDLE; err = 0; en = 1'b0; ex = 1'b0; live = 1'b1;
      end else begin
        code = int'({cl[0], cl[1]});
        nst  = tbl[st][code];
        en   = (st == M_E3) && (code == 0);
        ex   = (st == M_X3) && (code == 0);
`ifdef LION_GATE_ERRCNT_EN
        if (nst == M_RS && st != M_RS && err < 15) err++;
`endif
        st = nst;
        for (int c = 0; c < 2; c++) begin
          if (sy[c][SYN-1] != cl[c]) begin
            cn[c]++;
            if (cn[c] == DEB) begin
              cl[c] = ~cl[c];
              cn[c] = 0;
            end
          end else begin
            cn[c] = 0;
          end
          raw   = (c == 0) ? gate_a_raw : gate_b_raw;
          sy[c] = {sy[c][SYN-2:0], raw};
        end
      end
      if (live) begin
        s = {cl[0], cl[1], logic'(st != M_IDLE), en, ex, 4'(err)};
        sq.push_back(s);
        if (en || ex) begin
          p.kind = en ? 1 : 2;
          p.cyc  = ncyc;
          pq.push_back(p);
        end
      end
    end
  end

  // Monitor: compares status every cycle and pops a pulse record on each strobe.
  initial begin
    int     mcyc;
    stat_t  got, exp_s;
    pulse_t p;
    int     kind;
    mcyc = 0;
    forever begin
      @(negedge clk);
      mcyc++;
      if (sq.size() > 0) begin
        exp_s = sq.pop_front();
        got   = {gate_a, gate_b, busy, enter_pulse, exit_pulse, err_count};
        n_tests++;
        if (got !== exp_s) begin
          n_fail++;
          $display("FAIL status cyc=%0d {ga,gb,busy,en,ex,err} got %b required %b",
                   mcyc, got, exp_s);
        end
      end
      if (enter_pulse === 1'b1 || exit_pulse === 1'b1) begin
        kind = (enter_pulse === 1'b1) ? 1 : 2;
        n_tests++;
        if (pq.size() == 0) begin
          n_fail++;
          $display("FAIL pulse cyc=%0d got kind %0d required none", mcyc, kind);
        end else begin
          p = pq.pop_front();
          if (p.kind != kind || p.cyc != mcyc) begin
            n_fail++;
            $display("FAIL pulse got kind %0d at cyc %0d required kind %0d at cyc %0d",
                     kind, mcyc, p.kind, p.cyc);
          end
        end
      end
    end
  end

  task automatic hold(input logic a, input logic b, input int n);
    gate_a_raw = a;
    gate_b_raw = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic seq5(input logic [9:0] s);
    for (int i = 4; i >= 0; i--) hold(s[2*i+1], s[2*i], 10);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic a, b;
    int   n;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    seq5(10'b00_10_11_01_00); hold(1'b0, 1'b0, 10);
    seq5(10'b00_01_11_10_00); hold(1'b0, 1'b0, 10);
    hold(1'b0, 1'b0, 5); hold(1'b1, 1'b0, 3); hold(1'b0, 1'b0, 15);
    seq5(10'b00_10_11_10_00); hold(1'b0, 1'b0, 10);

    hold(1'b1, 1'b1, 10); hold(1'b0, 1'b0, 10);
    seq5(10'b00_10_11_01_00); hold(1'b0, 1'b0, 10);
    repeat (16) begin
      hold(1'b1, 1'b1, 10);
      hold(1'b0, 1'b0, 10);
    end

    // Reset while the FSM sits in E2, then both beams stay blocked.
    hold(1'b1, 1'b0, 10); hold(1'b1, 1'b1, 10);
    pulse_reset();
    hold(1'b1, 1'b1, 20); hold(1'b0, 1'b0, 20);

    repeat (400) begin
      if ($urandom_range(0, 39) == 0) pulse_reset();
      a = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      n = int'($urandom_range(1, 12));
      hold(a, b, n);
    end
    hold(1'b0, 1'b0, 30);

    n_tests++;
    if (pq.size() != 0) begin
      n_fail++;
      $display("FAIL pending_pulses got %0d required 0", pq.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lion_gate_decoder.md
LION_GATE_DECODER -- requirements
Module: lion_gate_decoder

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16, meaning consecutive stable cycles before a gate changes its clean level (legal range 1..255).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning flip-flop depth of each input synchronizer (legal range >=2).
REQ-003 SHALL have port clk, input, 1, meaning the single clock for the whole block.
REQ-004 SHALL have port reset, input, 1, meaning reset; synchronous and active-high.
REQ-005 SHALL have port gate_a_raw, input, 1, meaning the asynchronous outer light barrier; 1 = beam blocked.
REQ-006 SHALL have port gate_b_raw, input, 1, meaning the asynchronous inner light barrier; 1 = beam blocked.
REQ-007 SHALL have port enter_pulse, output, 1, meaning a one-cycle strobe for each completed entry.
REQ-008 SHALL have port exit_pulse, output, 1, meaning a one-cycle strobe for each completed exit.
REQ-009 SHALL have port gate_a, output, 1, meaning the debounced level of gate A.
REQ-010 SHALL have port gate_b, output, 1, meaning the debounced level of gate B.
REQ-011 SHALL have port busy, output, 1, meaning the FSM is not in IDLE.
REQ-012 SHALL have port err_count, output, 4, meaning a saturating count of illegal gate sequences.

Function
REQ-013 SHALL pass each raw input through a SYNC_STAGES-deep synchronizer before any other logic uses it.
REQ-014 SHALL use a per-channel debounce counter that increments while the synchronized value differs from the clean value, and clears when they are equal.
REQ-015 SHALL toggle the clean level and clear the counter on the edge where the counter would reach DEBOUNCE_CYCLES.
  - A glitch shorter than DEBOUNCE_CYCLES therefore never changes the clean level.
REQ-016 SHALL decode the gate code {gate_a, gate_b} with these FSM states: IDLE, E1, E2, E3, X1, X2, X3, RESYNC.
REQ-017 SHALL apply these transitions from IDLE: 10 goes to E1; 01 goes to X1; 11 goes to RESYNC and is counted as an error.
REQ-018 SHALL apply these entry-path transitions:
  - E1: 00 goes to IDLE (abort, no pulse); 11 goes to E2; 01 goes to RESYNC (error).
  - E2: 10 goes to E1; 01 goes to E3; 00 goes to RESYNC (error).
  - E3: 00 goes to IDLE and asserts enter_pulse; 11 goes to E2; 10 goes to RESYNC (error).
REQ-019 SHALL apply the exit path as the mirror of the entry path:
  - X1 holds 01, X2 holds 11, X3 holds 10.
  - X3 to 00 asserts exit_pulse.
  - X1 to 00 is an abort.
  - Codes that skip a step go to RESYNC (error).
REQ-020 SHALL leave RESYNC only when the code is 00, going to IDLE with no pulse.
REQ-021 SHALL register enter_pulse and exit_pulse so that each is high for exactly one cycle, starting the cycle after the clean code becomes 00.
  - The two pulses SHALL never be high together.
REQ-022 SHALL give a clean, stable transition a latency from raw edge to pulse of SYNC_STAGES + DEBOUNCE_CYCLES + 1 cycles.
REQ-023 SHALL have no state change when the code is unchanged; staying in any state is legal indefinitely.
REQ-024 SHALL increment err_count by 1 on each transition into RESYNC, saturating at 15 with no wrap.

Reset
REQ-025 SHALL, on reset, clear in the next cycle:
  - synchronizer flops, debounce counters, gate_a, gate_b;
  - FSM to IDLE;
  - enter_pulse, exit_pulse, busy, err_count.
REQ-026 SHALL, when reset is asserted mid-sequence, discard the partial sequence with no pulse emitted.
REQ-027 SHALL, when both beams are blocked as reset is released, debounce up to 11 and enter RESYNC (one error) once the code settles.

Configuration
REQ-028 SHALL include the err_count register and its saturation logic when LION_GATE_ERRCNT_EN is defined.
REQ-029 SHALL, when LION_GATE_ERRCNT_EN is undefined, tie err_count to 0 and leave all FSM behaviour, including RESYNC, unchanged.

Structure
REQ-030 SHALL take the FSM state typedef, the ERR_CNT_W=4 constant and the default SYNC_STAGES from a shared package lion_gate_pkg.
REQ-031 SHALL implement the synchronizer plus debouncer as sub-module gate_debounce, instantiated once per gate.

Verification (DEBOUNCE_CYCLES=4, SYNC_STAGES=2, each code held 10 cycles)
REQ-032 SHALL cover: codes 00,10,11,01,00 -> exactly one enter_pulse 7 cycles after the final raw edge; no exit_pulse; err_count 0.
REQ-033 SHALL cover: codes 00,01,11,10,00 -> exactly one exit_pulse; busy high from X1 until the pulse cycle.
REQ-034 SHALL cover: a 3-cycle high glitch on gate_a_raw -> gate_a stays 0, busy stays 0, no pulses.
REQ-035 SHALL cover: codes 00,10,11,10,00 (backing out) -> no pulse, err_count 0, FSM ends in IDLE.
REQ-036 SHALL cover: 00 jumping to 11 simultaneously, then 00, then a legal entry -> err_count 1, one enter_pulse; 16 further illegal jumps -> err_count holds 15.
REQ-037 SHALL cover: reset asserted for 1 cycle while in E2 -> next cycle FSM IDLE, gate_a/gate_b 0, err_count 0, no pulse emitted.
